hssl_lpbk_tester: RTL and testbench

HSSL_LPBK_TESTER -- requirements
Module: hssl_lpbk_tester

---
 rtl/hssl_lpbk_tester.sv | 176 +++++++++++++++++
 tb/tb_hssl_lpbk_tester.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssl_lpbk_tester.sv
// rtl/hssl_lpbk_tester.sv - multi-channel LFSR loopback traffic generator and checker (optional LPBK_ERR_INJECT_EN)
module hssl_lpbk_tester #(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [31:0]             cfg_words,
    output logic [NUM_CH*32-1:0]    tx_data,
    output logic [NUM_CH-1:0]       tx_vld,
    input  logic [NUM_CH-1:0]       tx_rdy,
    input  logic [NUM_CH*32-1:0]    rx_data,
    input  logic [NUM_CH-1:0]       rx_vld,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       lock,
    output logic [NUM_CH*CNT_W-1:0] err_cnt
`ifdef LPBK_ERR_INJECT_EN
    ,
    input  logic [NUM_CH-1:0]       err_inj
`endif
);

    localparam logic [31:0] POLY       = 32'h80200003;
    localparam logic [31:0] SEED       = 32'hACE10000;
    localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [31:0]       words_q;
    logic [31:0]       drain_cnt;
    logic [31:0]       sent_q [NUM_CH];
    logic [31:0]       lfsr_q [NUM_CH];
    logic [31:0]       exp_q  [NUM_CH];
    logic [CNT_W-1:0]  err_q  [NUM_CH];
    logic [NUM_CH-1:0] lock_q;
    logic [NUM_CH-1:0] more;
    logic [NUM_CH-1:0] hs;
    logic [NUM_CH-1:0] flip_q;
    logic              start_go;
    logic              chk_en;
    logic              all_sent;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? POLY : 32'h0);
    endfunction

    // A start is only honoured when no test is in flight
    assign start_go = start && (state == S_IDLE || state == S_DONE);
    assign chk_en   = (state == S_RUN) || (state == S_DRAIN);
    assign all_sent = ~|more;
    assign busy     = chk_en;
    assign done     = (state == S_DONE);
    assign lock     = lock_q;

    // Per-channel transmit qualifiers, payload masking and counter flattening
    always_comb begin
        more    = '0;
        hs      = '0;
        tx_vld  = '0;
        tx_data = '0;
        err_cnt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            more[c]                     = sent_q[c] < words_q;
            tx_vld[c]                   = (state == S_RUN) && more[c];
            hs[c]                       = tx_vld[c] && tx_rdy[c];
            tx_data[32*c +: 32]         = tx_vld[c] ? (lfsr_q[c] ^ {31'b0, flip_q[c]}) : 32'h0;
            err_cnt[CNT_W*c +: CNT_W]   = err_q[c];
        end
    end

    // Next-state decode for the test sequencer
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = (cfg_words == 32'd0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (stop || all_sent) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Counts cycles spent in DRAIN so late loopback words are still checked
    always_ff @(posedge clk) begin
        if (reset || state != S_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 32'd1;
        end
    end

    // Generators advance on handshake; checkers self-seed from the first received word
    always_ff @(posedge clk) begin
        if (reset) begin
            words_q <= '0;
            lock_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sent_q[c] <= '0;
                lfsr_q[c] <= '0;
                exp_q[c]  <= '0;
                err_q[c]  <= '0;
            end
        end else if (start_go) begin
            words_q <= cfg_words;
            lock_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sent_q[c] <= '0;
                lfsr_q[c] <= SEED | 32'(c);
                err_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hs[c]) begin
                    sent_q[c] <= sent_q[c] + 32'd1;
                    lfsr_q[c] <= lfsr_next(lfsr_q[c]);
                end
                if (chk_en && rx_vld[c]) begin
                    if (!lock_q[c]) begin
                        lock_q[c] <= 1'b1;
                        exp_q[c]  <= lfsr_next(rx_data[32*c +: 32]);
                    end else begin
                        if (rx_data[32*c +: 32] != exp_q[c] && err_q[c] != {CNT_W{1'b1}}) begin
                            err_q[c] <= err_q[c] + 1'b1;
                        end
                        exp_q[c] <= lfsr_next(exp_q[c]);
                    end
                end
            end
        end
    end

`ifdef LPBK_ERR_INJECT_EN
    // Holds a requested bit-0 flip until the next word on that channel is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            flip_q <= '0;
        end else begin
            flip_q <= (flip_q & ~hs) | err_inj;
        end
    end
`else
    assign flip_q = '0;
`endif

endmodule

// File: tb/tb_hssl_lpbk_tester.sv
// tb/tb_hssl_lpbk_tester.sv - scoreboard bench for hssl_lpbk_tester with randomized loopback traffic
module tb_hssl_lpbk_tester;

    localparam int NCH = 2;
    localparam int CW  = 16;
    localparam logic [31:0] POLY = 32'h80200003;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [31:0]       cfg_words = '0;
    logic [NCH*32-1:0] tx_data;
    logic [NCH-1:0]    tx_vld;
    logic [NCH-1:0]    tx_rdy = '1;
    logic [NCH*32-1:0] rx_data = '0;
    logic [NCH-1:0]    rx_vld = '0;
    logic              busy;
    logic              done;
    logic [NCH-1:0]    lock;
    logic [NCH*CW-1:0] err_cnt;
    logic [NCH-1:0]    err_inj = '0;

    logic        s_start = 1'b0;
    logic [31:0] s_cfg = '0;
    logic [31:0] s_tx_data;
    logic [0:0]  s_tx_vld;
    logic [0:0]  s_tx_rdy = 1'b1;
    logic [31:0] s_rx_data;
    logic [0:0]  s_rx_vld;
    logic        s_busy;
    logic        s_done;
    logic [0:0]  s_lock;
    logic [3:0]  s_err;
`ifdef LPBK_ERR_INJECT_EN
    logic [0:0]  s_err_inj = '0;
`endif

    always #5 clk = ~clk;

    hssl_lpbk_tester #(.NUM_CH(NCH), .CNT_W(CW), .DRAIN_CYC(64)) u_dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .cfg_words(cfg_words),
        .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
        .rx_data(rx_data), .rx_vld(rx_vld),
        .busy(busy), .done(done), .lock(lock), .err_cnt(err_cnt)
`ifdef LPBK_ERR_INJECT_EN
        , .err_inj(err_inj)
`endif
    );

    hssl_lpbk_tester #(.NUM_CH(1), .CNT_W(4), .DRAIN_CYC(8)) u_small (
        .clk(clk), .reset(reset), .start(s_start), .stop(1'b0), .cfg_words(s_cfg),
        .tx_data(s_tx_data), .tx_vld(s_tx_vld), .tx_rdy(s_tx_rdy),
        .rx_data(s_rx_data), .rx_vld(s_rx_vld),
        .busy(s_busy), .done(s_done), .lock(s_lock), .err_cnt(s_err)
`ifdef LPBK_ERR_INJECT_EN
        , .err_inj(s_err_inj)
`endif
    );

    // small instance: direct loopback until locked, then a stuck-at-zero link
    assign s_rx_vld  = s_tx_vld;
    assign s_rx_data = s_lock[0] ? 32'h0 : s_tx_data;

    int checks = 0;
    int passes = 0;

    logic [31:0] exp_q   [NCH][$];
    logic [31:0] rx_hist [NCH][$];
    logic [31:0] s_hist  [$];
    int          hs_cnt  [NCH];
    logic        pv      [NCH][3];
    logic [31:0] pd      [NCH][3];
    logic        prev_stall [NCH];
    logic [31:0] prev_d  [NCH];
    logic        inj_exp [NCH];
    int          corrupt_ch = -1;
    int          corrupt_idx = 0;
    logic [31:0] corrupt_mask = '0;
    bit          rdy_rand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] m_next(input logic [31:0] x);
        return (x >> 1) ^ ((x & 32'd1) != 0 ? POLY : 32'd0);
    endfunction

    // errors a self-seeding checker must report for a received sequence
    function automatic int model_err(input logic [31:0] q[$], input int maxv);
        logic [31:0] ref_w;
        int n = 0;
        if (q.size() == 0) return 0;
        ref_w = q[0];
        for (int i = 1; i < q.size(); i++) begin
            ref_w = m_next(ref_w);
            if (q[i] != ref_w) n++;
        end
        return (n > maxv) ? maxv : n;
    endfunction

    initial begin
        for (int c = 0; c < NCH; c++) begin
            hs_cnt[c] = 0;
            prev_stall[c] = 1'b0;
            prev_d[c] = '0;
            inj_exp[c] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                pv[c][k] = 1'b0;
                pd[c][k] = '0;
            end
        end
    end

    // ready driver, changed just after the active edge
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NCH; c++) tx_rdy[c] = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // monitor: scoreboard pop on every handshake, stall stability, 3-stage loopback
    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] d;
            logic [31:0] e;
            logic        hs;
            d  = tx_data[32*c +: 32];
            hs = tx_vld[c] && tx_rdy[c] && !reset;
            rx_vld[c] = pv[c][2];
            rx_data[32*c +: 32] = pd[c][2];
            if (pv[c][2] && busy && !reset) rx_hist[c].push_back(pd[c][2]);
            pv[c][2] = pv[c][1]; pd[c][2] = pd[c][1];
            pv[c][1] = pv[c][0]; pd[c][1] = pd[c][0];
            if (prev_stall[c] && tx_vld[c] && !reset) chk("tx_stable", d, prev_d[c]);
            prev_stall[c] = tx_vld[c] && !tx_rdy[c] && !reset;
            prev_d[c] = d;
            if (hs) begin
                if (exp_q[c].size() == 0) begin
                    chk("tx_unexpected_word", 64'd1, 64'd0);
                    e = d;
                end else begin
                    e = exp_q[c].pop_front();
                end
                if (inj_exp[c]) e[0] = ~e[0];
                inj_exp[c] = 1'b0;
                chk("tx_data", d, e);
                if (c == corrupt_ch && hs_cnt[c] == corrupt_idx) d = d ^ corrupt_mask;
                hs_cnt[c]++;
            end
            if (err_inj[c] && !reset) inj_exp[c] = 1'b1;
            pv[c][0] = hs;
            pd[c][0] = d;
        end
        if (s_rx_vld[0] && s_busy && !reset) s_hist.push_back(s_rx_data);
    end

    task automatic do_start(input int words);
        for (int c = 0; c < NCH; c++) begin
            logic [31:0] s;
            exp_q[c].delete();
            rx_hist[c].delete();
            hs_cnt[c] = 0;
            s = 32'hACE10000 | 32'(c);
            for (int i = 0; i < words; i++) begin
                exp_q[c].push_back(s);
                s = m_next(s);
            end
        end
        cfg_words = 32'(words);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while (hs_cnt[0] < n && k < 1000) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("word_reached", {63'd0, hs_cnt[0] >= n}, 64'd1);
    endtask

    task automatic end_checks(input int words);
        chk("busy_after", {63'd0, busy}, 64'd0);
        for (int c = 0; c < NCH; c++) begin
            chk("hs_count", 64'(hs_cnt[c]), 64'(words));
            chk("err_cnt", 64'(err_cnt[CW*c +: CW]), 64'(model_err(rx_hist[c], 65535)));
            chk("lock", {63'd0, lock[c]}, {63'd0, rx_hist[c].size() > 0});
        end
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx_vld", 64'(tx_vld), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_lock", 64'(lock), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // zero words: straight to DRAIN, nothing sent
        do_start(0);
        chk("zero_busy", {63'd0, busy}, 64'd1);
        chk("zero_tx_vld", 64'(tx_vld), 64'd0);
        wait_done(200);
        end_checks(0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
        chk("stop_ignored_done", {63'd0, done}, 64'd1);

        // full-rate loopback
        rdy_rand = 1'b0;
        do_start(100);
        wait_done(500);
        end_checks(100);
        chk("lock_both", 64'(lock), 64'd3);

        // random backpressure, a start mid-run must be ignored
        rdy_rand = 1'b1;
        do_start(100);
        repeat (30) @(negedge clk);
        cfg_words = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(800);
        end_checks(100);

        // bit 5 of word 10 on channel 1 corrupted in the link
        corrupt_ch = 1; corrupt_idx = 10; corrupt_mask = 32'h20;
        do_start(100);
        wait_done(800);
        end_checks(100);
        chk("corrupt_err1", 64'(err_cnt[CW +: CW]), 64'd1);
        chk("corrupt_err0", 64'(err_cnt[0 +: CW]), 64'd0);
        corrupt_ch = -1;

        // stop after word 40
        rdy_rand = 1'b0;
        do_start(100);
        wait_hs(40);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_tx_vld", 64'(tx_vld), 64'd0);
        chk("stop_busy", {63'd0, busy}, 64'd1);
        wait_done(300);
        end_checks(40);

        // reset mid-run
        rdy_rand = 1'b1;
        do_start(100);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_tx_vld", 64'(tx_vld), 64'd0);
        chk("midrst_tx_data", 64'(tx_data), 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_lock", 64'(lock), 64'd0);
        chk("midrst_err", 64'(err_cnt), 64'd0);
        repeat (10) @(negedge clk);

        // randomized lengths and link corruptions
        for (int t = 0; t < 6; t++) begin
            int w;
            w = $urandom_range(1, 60);
            corrupt_ch = $urandom_range(0, 2) - 1;
            corrupt_idx = $urandom_range(0, w - 1);
            corrupt_mask = 32'd1 << $urandom_range(0, 31);
            do_start(w);
            wait_done(600);
            end_checks(w);
        end
        corrupt_ch = -1;

`ifdef LPBK_ERR_INJECT_EN
        rdy_rand = 1'b0;
        do_start(60);
        wait_hs(20);
        @(posedge clk);
        #1 err_inj = 2'b01;
        @(posedge clk);
        #1 err_inj = 2'b00;
        @(negedge clk);
        wait_done(400);
        end_checks(60);
        chk("inject_err0", 64'(err_cnt[0 +: CW]), 64'd1);
        chk("inject_err1", 64'(err_cnt[CW +: CW]), 64'd0);
`endif

        // narrow counter saturates against a stuck link
        s_hist.delete();
        s_cfg = 32'd40;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int n = 0; n < 200 && !s_done; n++) @(negedge clk);
        chk("small_done", {63'd0, s_done}, 64'd1);
        chk("small_err_model", 64'(s_err), 64'(model_err(s_hist, 15)));
        chk("small_err_sat", 64'(s_err), 64'd15);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
